// File: rtl/audiodac_burst_feeder_pkg.sv
// audiodac_burst_feeder_pkg
//   Shared definitions for the audiodac burst feeder:
//   - chan_state_e : per-channel handshake FSM states (IDLE=0, REQ=1, ACKW=2)
//   - CAP_W        : width of the optional delta-sigma capture word
//   - ch_width()   : channel index width, never below one bit
package audiodac_burst_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACKW = 2'd2
  } chan_state_e;

  localparam int CAP_W = 32;

  function automatic int ch_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/audiodac_burst_feeder_if.sv
// audiodac_burst_feeder_if
//   Host sample stream plus the per-channel DAC FIFO write ports.
//   Signal names keep the feeder-side view (_i into the feeder, _o out of it).
//   modport slave  : the feeder
//   modport master : host bridge / DAC FIFO side
//   s_data_i, s_valid_i, s_ready_o, s_ch_o          host valid/ready stream
//   fifo_data_o, fifo_rdy_o, fifo_ack_i             per-channel rdy/ack write port
//   fifo_full_i, fifo_empty_i                       per-channel FIFO level flags
interface audiodac_burst_feeder_if
  import audiodac_burst_feeder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CH     = 2
);

  localparam int CH_W = ch_width(CH);

  logic [DATA_W-1:0]    s_data_i;
  logic                 s_valid_i;
  logic                 s_ready_o;
  logic [CH_W-1:0]      s_ch_o;
  logic [CH*DATA_W-1:0] fifo_data_o;
  logic [CH-1:0]        fifo_rdy_o;
  logic [CH-1:0]        fifo_ack_i;
  logic [CH-1:0]        fifo_full_i;
  logic [CH-1:0]        fifo_empty_i;

  modport slave (
    input  s_data_i, s_valid_i, fifo_ack_i, fifo_full_i, fifo_empty_i,
    output s_ready_o, s_ch_o, fifo_data_o, fifo_rdy_o
  );

  modport master (
    output s_data_i, s_valid_i, fifo_ack_i, fifo_full_i, fifo_empty_i,
    input  s_ready_o, s_ch_o, fifo_data_o, fifo_rdy_o
  );

endinterface

// File: rtl/audiodac_burst_feeder_chan.sv
// audiodac_feeder_chan
//   One DAC channel: rdy/ack handshake FSM, sample register and
//   full/empty burst-hysteresis wait flag.
//   CLK, RESET_N  clock, synchronous active-low reset
//   accept_i      a sample for this channel is accepted this cycle
//   data_i        sample to latch on accept
//   ack_i         FIFO acknowledge
//   full_i        FIFO full  (sets wait flag)
//   empty_i       FIFO empty (clears wait flag, wins over full)
//   rdy_o         data-ready to the FIFO
//   data_o        latched sample
//   idle_o        FSM is IDLE and can take a new sample
//   wait_o        wait flag
module audiodac_feeder_chan
  import audiodac_burst_feeder_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ack_i,
  input  logic              full_i,
  input  logic              empty_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              idle_o,
  output logic              wait_o
);

  chan_state_e state_q, state_d;

  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_i) state_d = REQ;
      REQ:     if (ack_i)    state_d = ACKW;
      ACKW:    if (!ack_i)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy_o  = (state_q == REQ);
    idle_o = (state_q == IDLE);
  end

  // accept only happens in IDLE, so data stays stable for the whole REQ phase
  always_ff @(posedge CLK) begin
    if (!RESET_N)      data_o <= '0;
    else if (accept_i) data_o <= data_i;
  end

  // empty has priority so a full/empty glitch in one cycle releases the channel
  always_ff @(posedge CLK) begin
    if (!RESET_N)     wait_o <= 1'b0;
    else if (empty_i) wait_o <= 1'b0;
    else if (full_i)  wait_o <= 1'b1;
  end

endmodule

// File: rtl/audiodac_burst_feeder.sv
// audiodac_burst_feeder
//   Splits an interleaved host sample stream (ch0, ch1, .., chN-1, ch0, ..)
//   across CH audiodac FIFO write ports, one sample in flight per channel.
//   The stream stalls on a blocked channel; samples are never reordered.
//   Ports:
//   CLK, RESET_N   clock, synchronous active-low reset
//   enable_i       feeder enable (gates new accepts, irq, underrun, capture)
//   bus            audiodac_burst_feeder_if.slave (host stream + FIFO ports)
//   irq_o          registered OR of fifo_empty_i, gated by enable_i
//   undr_cnt_o     saturating count of cycles with a rising FIFO-empty edge
//   Optional (macro AUDIODAC_FEEDER_CAPTURE_EN):
//   ds_i           delta-sigma bit, shifted in MSB-first while enabled
//   cap_data_o     last complete 32-bit capture word
//   cap_valid_o    one-cycle pulse when cap_data_o is updated
module audiodac_burst_feeder
  import audiodac_burst_feeder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CH     = 2,
  parameter int UNDR_W = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 enable_i,
  audiodac_burst_feeder_if.slave bus,
  output logic                 irq_o,
  output logic [UNDR_W-1:0]    undr_cnt_o
`ifdef AUDIODAC_FEEDER_CAPTURE_EN
  ,
  input  logic                 ds_i,
  output logic [CAP_W-1:0]     cap_data_o,
  output logic                 cap_valid_o
`endif
);

  localparam int CH_W = ch_width(CH);

  logic [CH_W-1:0]   rr_q;
  logic              accept;
  logic [CH-1:0]     chan_accept;
  logic [CH-1:0]     chan_rdy;
  logic [CH-1:0]     chan_idle;
  logic [CH-1:0]     chan_wait;
  logic [DATA_W-1:0] chan_data [CH];
  logic [CH-1:0]     empty_q;
  logic              empty_rise;

  // RESET_N gating keeps the host from seeing ready while the block is held in reset
  assign bus.s_ready_o = RESET_N & enable_i & chan_idle[rr_q]
                       & ~bus.fifo_full_i[rr_q] & ~chan_wait[rr_q];
  assign bus.s_ch_o    = rr_q;
  assign accept        = bus.s_valid_i & bus.s_ready_o;

  always_ff @(posedge CLK) begin
    if (!RESET_N)                        rr_q <= '0;
    else if (accept && rr_q == CH_W'(CH - 1)) rr_q <= '0;
    else if (accept)                     rr_q <= rr_q + 1'b1;
  end

  always_comb begin
    chan_accept = '0;
    for (int c = 0; c < CH; c++) begin
      if (rr_q == CH_W'(c)) chan_accept[c] = accept;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    audiodac_feeder_chan #(.DATA_W(DATA_W)) u_chan (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .accept_i (chan_accept[g]),
      .data_i   (bus.s_data_i),
      .ack_i    (bus.fifo_ack_i[g]),
      .full_i   (bus.fifo_full_i[g]),
      .empty_i  (bus.fifo_empty_i[g]),
      .rdy_o    (chan_rdy[g]),
      .data_o   (chan_data[g]),
      .idle_o   (chan_idle[g]),
      .wait_o   (chan_wait[g])
    );
  end

  always_comb begin
    bus.fifo_data_o = '0;
    for (int c = 0; c < CH; c++) begin
      bus.fifo_data_o[c*DATA_W +: DATA_W] = chan_data[c];
    end
  end

  assign bus.fifo_rdy_o = chan_rdy;

  // Edge history follows the pins even through reset, so an empty flag held
  // across reset is not counted as a fresh underrun.
  always_ff @(posedge CLK) begin
    empty_q <= bus.fifo_empty_i;
  end

  assign empty_rise = |(bus.fifo_empty_i & ~empty_q);

  always_ff @(posedge CLK) begin
    if (!RESET_N) undr_cnt_o <= '0;
    else if (enable_i && empty_rise && (undr_cnt_o != {UNDR_W{1'b1}}))
      undr_cnt_o <= undr_cnt_o + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) irq_o <= 1'b0;
    else          irq_o <= enable_i & (|bus.fifo_empty_i);
  end

`ifdef AUDIODAC_FEEDER_CAPTURE_EN
  localparam int CAP_CNT_W = $clog2(CAP_W);

  logic [CAP_W-1:0]     cap_sh_q;
  logic [CAP_CNT_W-1:0] cap_cnt_q;
  logic [CAP_W-1:0]     cap_next;

  assign cap_next = {cap_sh_q[CAP_W-2:0], ds_i};

  // Disabling keeps the partial word but restarts the bit count.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cap_sh_q    <= '0;
      cap_cnt_q   <= '0;
      cap_data_o  <= '0;
      cap_valid_o <= 1'b0;
    end else begin
      cap_valid_o <= 1'b0;
      if (enable_i) begin
        if (cap_cnt_q == CAP_CNT_W'(CAP_W - 1)) begin
          cap_data_o  <= cap_next;
          cap_valid_o <= 1'b1;
          cap_sh_q    <= '0;
          cap_cnt_q   <= '0;
        end else begin
          cap_sh_q  <= cap_next;
          cap_cnt_q <= cap_cnt_q + 1'b1;
        end
      end else begin
        cap_cnt_q <= '0;
      end
    end
  end
`endif

endmodule
